// File: rtl/frame_bank_scheduler.sv
// frame_bank_scheduler: triple-buffer bank scheduler between the camera word
// stream and the frame-buffer RAM. Writes incoming words into bank W and
// exposes bank R to the display. Banks swap only at frame boundaries, so the
// display never shows a torn frame.
// Optional macro FRAME_SCHED_STATS_EN adds frames_done, frames_trunc and
// frames_repeat counters.
module frame_bank_scheduler #(
    parameter int FRAME_WORDS = 76800,
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_frame_start,
    input  logic              wr_frame_end,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_frame_start,
    output logic              ram_we,
    output logic [1:0]        ram_wr_bank,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic [1:0]        rd_bank,
    output logic              frame_ready,
    output logic              overflow
`ifdef FRAME_SCHED_STATS_EN
    ,
    output logic [15:0]       frames_done,
    output logic [15:0]       frames_trunc,
    output logic [15:0]       frames_repeat
`endif
);

    // One extra bit so the counter can hold FRAME_WORDS itself.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_WORDS);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wcnt;
    logic [CNT_W-1:0] wcnt_nxt;
    logic             accept;
    logic             drop;
    logic             complete;
    logic             trunc;

    logic [1:0] w_bank;
    logic [1:0] r_bank;
    logic [1:0] l_bank;
    logic       l_valid;
    logic [1:0] w_bank_nxt;
    logic [1:0] r_bank_nxt;
    logic [1:0] l_bank_nxt;
    logic       l_valid_nxt;
    logic       repeat_rd;

    // Writer FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Writer FSM next-state: a start always (re)enters ACTIVE, an end leaves it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr_frame_start) state_nxt = ACTIVE;
            ACTIVE: begin
                if (wr_frame_start)    state_nxt = ACTIVE;
                else if (wr_frame_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Writer FSM outputs: word accept/drop and the frame-end verdict. A word
    // arriving with the end pulse is counted before completion is judged.
    always_comb begin
        accept   = 1'b0;
        drop     = 1'b0;
        complete = 1'b0;
        trunc    = 1'b0;
        wcnt_nxt = wcnt;
        case (state)
            IDLE: begin
                if (wr_frame_start) wcnt_nxt = '0;
            end
            ACTIVE: begin
                if (wr_frame_start) begin
                    trunc    = 1'b1;
                    wcnt_nxt = '0;
                end else begin
                    if (wr_valid) begin
                        if (wcnt < FULL) accept = 1'b1;
                        else             drop   = 1'b1;
                    end
                    wcnt_nxt = wcnt + CNT_W'(accept);
                    if (wr_frame_end) begin
                        if (wcnt_nxt == FULL) complete = 1'b1;
                        else                  trunc    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Bank rotation: completion is applied first, then the display swap sees
    // the freshly completed bank.
    always_comb begin
        w_bank_nxt  = w_bank;
        r_bank_nxt  = r_bank;
        l_bank_nxt  = l_bank;
        l_valid_nxt = l_valid;
        repeat_rd   = 1'b0;
        if (complete) begin
            l_bank_nxt  = w_bank;
            l_valid_nxt = 1'b1;
            // The three banks sum to 3, so this is the one neither R nor W.
            w_bank_nxt  = 2'd3 - r_bank - w_bank;
        end
        if (rd_frame_start) begin
            if (l_valid_nxt) begin
                r_bank_nxt  = l_bank_nxt;
                l_bank_nxt  = r_bank;
                l_valid_nxt = 1'b0;
            end else begin
                repeat_rd = 1'b1;
            end
        end
    end

    // Word counter and bank registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt    <= '0;
            w_bank  <= 2'd0;
            r_bank  <= 2'd1;
            l_bank  <= 2'd2;
            l_valid <= 1'b0;
        end else begin
            wcnt    <= wcnt_nxt;
            w_bank  <= w_bank_nxt;
            r_bank  <= r_bank_nxt;
            l_bank  <= l_bank_nxt;
            l_valid <= l_valid_nxt;
        end
    end

    // RAM port A: one-cycle registered copy of each accepted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_we      <= 1'b0;
            ram_wr_bank <= 2'd0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
        end else begin
            ram_we <= accept;
            if (accept) begin
                ram_wr_bank <= w_bank;
                ram_wr_addr <= wcnt[ADDR_W-1:0];
                ram_wr_data <= wr_data;
            end
        end
    end

    // Sticky overflow flag for words beyond a full frame.
    always_ff @(posedge clk) begin
        if (reset)     overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

    assign rd_bank     = r_bank;
    assign frame_ready = l_valid;

`ifdef FRAME_SCHED_STATS_EN
    // Wrapping frame statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            frames_done   <= '0;
            frames_trunc  <= '0;
            frames_repeat <= '0;
        end else begin
            if (complete)  frames_done   <= frames_done + 16'd1;
            if (trunc)     frames_trunc  <= frames_trunc + 16'd1;
            if (repeat_rd) frames_repeat <= frames_repeat + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Bench for frame_bank_scheduler with FRAME_WORDS=16: directed frame scenarios
// followed by randomized frames, all compared against a bank-rotation model.
module tb_frame_bank_scheduler;

    localparam int FW = 16;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_frame_start = 1'b0;
    logic          wr_frame_end = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_frame_start = 1'b0;
    logic          ram_we;
    logic [1:0]    ram_wr_bank;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [1:0]    rd_bank;
    logic          frame_ready;
    logic          overflow;
`ifdef FRAME_SCHED_STATS_EN
    logic [15:0]   frames_done;
    logic [15:0]   frames_trunc;
    logic [15:0]   frames_repeat;
`endif

    frame_bank_scheduler #(
        .FRAME_WORDS(FW),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_frame_start(wr_frame_start),
        .wr_frame_end  (wr_frame_end),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .rd_frame_start(rd_frame_start),
        .ram_we        (ram_we),
        .ram_wr_bank   (ram_wr_bank),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_data   (ram_wr_data),
        .rd_bank       (rd_bank),
        .frame_ready   (frame_ready),
        .overflow      (overflow)
`ifdef FRAME_SCHED_STATS_EN
        ,
        .frames_done   (frames_done),
        .frames_trunc  (frames_trunc),
        .frames_repeat (frames_repeat)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int wr_seen  = 0;

    // Reference model: which physical bank holds what.
    int          m_w, m_r, m_l;
    bit          m_lv, m_act, m_ovf;
    int          m_cnt;
    bit          exp_we;
    int          exp_addr, exp_bank;
    logic [31:0] exp_data;
    logic [15:0] m_done, m_trunc, m_rep;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_errors++;
            $display("FAIL %s observed %0h required %0h", tag, obs, req);
        end
    endtask

    task automatic model_update(input bit rst, input bit fs, input bit v, input bit fe,
                                input bit rs, input logic [31:0] d);
        int old_r;
        exp_we = 1'b0;
        if (rst) begin
            m_w = 0; m_r = 1; m_l = 2; m_lv = 0;
            m_act = 0; m_cnt = 0; m_ovf = 0;
            m_done = 0; m_trunc = 0; m_rep = 0;
            return;
        end
        if (fs) begin
            if (m_act) m_trunc++;
            m_act = 1;
            m_cnt = 0;
        end else if (m_act) begin
            if (v) begin
                if (m_cnt < FW) begin
                    exp_we = 1'b1; exp_addr = m_cnt; exp_bank = m_w; exp_data = d;
                    m_cnt++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (fe) begin
                m_act = 0;
                if (m_cnt == FW) begin
                    m_l = m_w;
                    m_lv = 1;
                    m_done++;
                    for (int b = 0; b < 3; b++)
                        if (b != m_r && b != m_l) m_w = b;
                end else begin
                    m_trunc++;
                end
            end
        end
        if (rs) begin
            if (m_lv) begin
                old_r = m_r; m_r = m_l; m_l = old_r; m_lv = 0;
            end else begin
                m_rep++;
            end
        end
    endtask

    // One clock: drive on the falling edge, compare just after the rising edge.
    task automatic step(input bit rst, input bit fs, input bit v, input bit fe,
                        input bit rs, input logic [31:0] d);
        @(negedge clk);
        reset = rst; wr_frame_start = fs; wr_valid = v;
        wr_frame_end = fe; rd_frame_start = rs; wr_data = d;
        @(posedge clk);
        #1;
        model_update(rst, fs, v, fe, rs, d);
        if (ram_we) wr_seen++;
        check("ram_we", 32'(ram_we), 32'(exp_we));
        if (exp_we) begin
            check("ram_wr_addr", 32'(ram_wr_addr), 32'(exp_addr));
            check("ram_wr_bank", 32'(ram_wr_bank), 32'(exp_bank));
            check("ram_wr_data", ram_wr_data, exp_data);
        end
        check("rd_bank", 32'(rd_bank), 32'(m_r));
        check("frame_ready", 32'(frame_ready), 32'(m_lv));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef FRAME_SCHED_STATS_EN
        check("frames_done", 32'(frames_done), 32'(m_done));
        check("frames_trunc", 32'(frames_trunc), 32'(m_trunc));
        check("frames_repeat", 32'(frames_repeat), 32'(m_rep));
`endif
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0);
    endtask

    // Start pulse, nwords consecutive words, end pulse (optionally with a read start).
    task automatic send_frame(input int nwords, input bit rs_at_end);
        step(0, 1, 0, 0, 0, 32'h0);
        for (int i = 0; i < nwords; i++) step(0, 0, 1, 0, 0, $urandom);
        step(0, 0, 0, 1, rs_at_end, 32'h0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_addr", 32'(ram_wr_addr), 32'd0);
        check("rst_bank", 32'(ram_wr_bank), 32'd0);
        check("rst_data", ram_wr_data, 32'd0);
        check("rst_rd_bank", 32'(rd_bank), 32'd1);
        check("rst_ready", 32'(frame_ready), 32'd0);

        // Full frame into bank 0.
        wr_seen = 0;
        send_frame(FW, 0);
        idle();
        check("s1_writes", 32'(wr_seen), 32'd16);
        check("s1_ready", 32'(frame_ready), 32'd1);
        check("s1_rd_bank", 32'(rd_bank), 32'd1);

        // Display takes bank 0; next frame goes to bank 2.
        step(0, 0, 0, 0, 1, 32'h0);
        check("s2_rd_bank", 32'(rd_bank), 32'd0);
        check("s2_ready", 32'(frame_ready), 32'd0);
        send_frame(FW, 0);
        idle();
        check("s2_ready2", 32'(frame_ready), 32'd1);

        // Truncated frame leaves banks alone; bank 0 is rewritten next.
        do_reset();
        send_frame(10, 0);
        idle();
        check("s3_ready", 32'(frame_ready), 32'd0);
        send_frame(FW, 0);
        check("s3_ready2", 32'(frame_ready), 32'd1);

        // Overlong frame: 16 writes, sticky overflow, still complete.
        do_reset();
        wr_seen = 0;
        send_frame(18, 0);
        idle();
        check("s4_writes", 32'(wr_seen), 32'd16);
        check("s4_ovf", 32'(overflow), 32'd1);
        check("s4_ready", 32'(frame_ready), 32'd1);
        send_frame(5, 0);
        check("s4_ovf_sticky", 32'(overflow), 32'd1);

        // Completion and display start in the same cycle.
        do_reset();
        send_frame(FW, 1);
        check("s5_rd_bank", 32'(rd_bank), 32'd0);
        check("s5_ready", 32'(frame_ready), 32'd0);
        send_frame(FW, 0);
        step(0, 0, 0, 0, 1, 32'h0);
        check("s5_rd_bank2", 32'(rd_bank), 32'd2);

        // Reset in the middle of a frame after overflow was set.
        send_frame(18, 0);
        step(0, 1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, $urandom);
        step(1, 0, 1, 0, 0, 32'h1234);
        check("s6_we", 32'(ram_we), 32'd0);
        check("s6_ovf", 32'(overflow), 32'd0);
        check("s6_rd_bank", 32'(rd_bank), 32'd1);
        check("s6_ready", 32'(frame_ready), 32'd0);
`ifdef FRAME_SCHED_STATS_EN
        check("s6_done", 32'(frames_done), 32'd0);
        check("s6_trunc", 32'(frames_trunc), 32'd0);
        check("s6_repeat", 32'(frames_repeat), 32'd0);
`endif
        step(0, 0, 1, 1, 0, 32'h5678);
        check("s6_we_after", 32'(ram_we), 32'd0);
        send_frame(FW, 0);
        check("s6_ready2", 32'(frame_ready), 32'd1);

        // Randomized frames with gaps, restarts, stray pulses and display starts.
        for (int f = 0; f < 80; f++) begin
            int nw;
            nw = $urandom_range(8, 19);
            if ($urandom_range(0, 39) == 0) do_reset();
            step(0, 1, 0, 0, $urandom_range(0, 5) == 0, 32'h0);
            for (int i = 0; i < nw; i++) begin
                if ($urandom_range(0, 3) == 0) idle();
                if ($urandom_range(0, 29) == 0)
                    step(0, 1, 0, 0, $urandom_range(0, 5) == 0, 32'h0);
                step(0, 0, 1, 0, $urandom_range(0, 5) == 0, $urandom);
            end
            step(0, 0, $urandom_range(0, 1) == 1, 1, $urandom_range(0, 3) == 0, $urandom);
            for (int g = $urandom_range(0, 3); g > 0; g--)
                step(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 4) == 0, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
